// File: rtl/mcp_pkg.sv
// Shared types and helpers for the multicycle-path capture stage.
package mcp_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } mcp_state_e;

  localparam int MCP_MIN_CYCLES = 1;

  function automatic int mcp_cnt_w(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mcp_capture_pipe_hold_counter.sv
// Down-counter that times how long the launch word stays stable; stops at zero.
module mcp_hold_counter #(
  parameter int CNT_W = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_reg;

  // Saturates at zero: the terminal value is detected, never wrapped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (dec && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign zero = (cnt_reg == '0);

endmodule

// File: rtl/mcp_capture_pipe.sv
// Single-clock multicycle-path capture stage with valid/ready input and pulsed output.
// Optional launch parity check enabled by defining MCP_PARITY_EN (adds port par_err).
module mcp_capture_pipe
  import mcp_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int MCP_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
`ifdef MCP_PARITY_EN
  ,
  output logic             par_err
`endif
);

  localparam int MCP_EFF = (MCP_CYCLES < MCP_MIN_CYCLES) ? MCP_MIN_CYCLES : MCP_CYCLES;
  localparam int CNT_W = mcp_cnt_w(MCP_EFF);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MCP_EFF - 1);

  mcp_state_e state_reg, state_next;
  logic [WIDTH-1:0] launch_q_reg;
  logic [WIDTH-1:0] out_data_reg;
  logic             out_valid_reg;
  logic             cnt_zero;
  logic             accept;
  logic             capture;

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b1;
    capture    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (in_valid) state_next = HOLD;
      end
      HOLD: begin
        in_ready = cnt_zero;
        capture  = cnt_zero;
        if (cnt_zero && !in_valid) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign accept = in_valid && in_ready;
  assign busy   = (state_reg == HOLD);

  mcp_hold_counter #(
    .CNT_W(CNT_W)
  ) u_hold_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (accept),
    .load_val(LOAD_VAL),
    .dec     (busy && !cnt_zero),
    .zero    (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Capture reads the pre-edge launch word, so a same-edge reload is safe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      launch_q_reg  <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      out_valid_reg <= capture;
      if (capture) out_data_reg <= launch_q_reg;
      if (accept) launch_q_reg <= in_data;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;

`ifdef MCP_PARITY_EN
  logic par_reg;
  logic par_err_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_reg     <= 1'b0;
      par_err_reg <= 1'b0;
    end else begin
      if (accept) par_reg <= ^in_data;
      if (capture && ((^launch_q_reg) != par_reg)) par_err_reg <= 1'b1;
    end
  end

  assign par_err = par_err_reg;
`endif

endmodule

// File: tb/tb_mcp_capture_pipe.sv
// Randomised bench for mcp_capture_pipe at MCP_CYCLES 3, 1 and 4 against a timing model.
// With MCP_PARITY_EN defined, an extra MCP_CYCLES=2 instance exercises the parity flag.
module tb_mcp_capture_pipe;

  localparam int N = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       in_valid   [N];
  logic [7:0] in_data    [N];
  logic       in_ready_w [N];
  logic       out_valid_w[N];
  logic [7:0] out_data_w [N];
  logic       busy_w     [N];

  int total = 0;
  int bad = 0;
  int edge_n = 0;
  int pulses1 = 0;
  bit gap_en = 1'b0;

  // Upstream sources: a word stays presented until the stage accepts it.
  logic [7:0] src_mem[N][0:1023];
  int src_wr[N];
  int src_rd[N];

  // Model: at most one word in flight, emerging exactly MCP_CYCLES edges after acceptance.
  bit         pend_vld [N];
  int         pend_edge[N];
  logic [7:0] pend_data[N];
  logic [7:0] exp_data [N];
  bit         exp_ov   [N];

  mcp_capture_pipe #(.WIDTH(8), .MCP_CYCLES(3)) u_m3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready_w[0]),
    .in_data(in_data[0]), .out_valid(out_valid_w[0]), .out_data(out_data_w[0]), .busy(busy_w[0])
`ifdef MCP_PARITY_EN
    , .par_err()
`endif
  );

  mcp_capture_pipe #(.WIDTH(8), .MCP_CYCLES(1)) u_m1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready_w[1]),
    .in_data(in_data[1]), .out_valid(out_valid_w[1]), .out_data(out_data_w[1]), .busy(busy_w[1])
`ifdef MCP_PARITY_EN
    , .par_err()
`endif
  );

  mcp_capture_pipe #(.WIDTH(8), .MCP_CYCLES(4)) u_m4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready_w[2]),
    .in_data(in_data[2]), .out_valid(out_valid_w[2]), .out_data(out_data_w[2]), .busy(busy_w[2])
`ifdef MCP_PARITY_EN
    , .par_err()
`endif
  );

`ifdef MCP_PARITY_EN
  logic       pv = 1'b0;
  logic [7:0] pd = 8'h00;
  logic       p_ready, p_ov, p_busy, p_err;
  logic [7:0] p_out;

  mcp_capture_pipe #(.WIDTH(8), .MCP_CYCLES(2)) u_par (
    .clk(clk), .rst_n(rst_n), .in_valid(pv), .in_ready(p_ready), .in_data(pd),
    .out_valid(p_ov), .out_data(p_out), .busy(p_busy), .par_err(p_err)
  );
`endif

  function automatic int mc(input int i);
    case (i)
      0:       return 3;
      1:       return 1;
      default: return 4;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s at edge %0d: observed=%0h expected=%0h", tag, edge_n, obs, exp);
    end
  endtask

  task automatic push(input int i, input logic [7:0] d);
    if (src_wr[i] < 1024) begin
      src_mem[i][src_wr[i]] = d;
      src_wr[i]++;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      pend_vld[i] = 1'b0;
      exp_data[i] = 8'h00;
      exp_ov[i]   = 1'b0;
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < N; i++) begin
      chk($sformatf("in_ready[m%0d]", mc(i)), 32'(in_ready_w[i]),
          32'(!pend_vld[i] || (edge_n + 1 - pend_edge[i] >= mc(i))));
      chk($sformatf("out_valid[m%0d]", mc(i)), 32'(out_valid_w[i]), 32'(exp_ov[i]));
      chk($sformatf("out_data[m%0d]", mc(i)), 32'(out_data_w[i]), 32'(exp_data[i]));
      chk($sformatf("busy[m%0d]", mc(i)), 32'(busy_w[i]), 32'(pend_vld[i]));
    end
    if (pend_vld[0]) chk("launch_stable[m3]", 32'(u_m3.launch_q_reg), 32'(pend_data[0]));
  endtask

  task automatic step();
    bit rdy;
    for (int i = 0; i < N; i++) begin
      in_valid[i] = rst_n && (src_rd[i] != src_wr[i]) && (!gap_en || ($urandom_range(0, 3) != 0));
      in_data[i]  = (src_rd[i] != src_wr[i]) ? src_mem[i][src_rd[i]] : 8'h00;
    end
    @(posedge clk);
    edge_n++;
    for (int i = 0; i < N; i++) begin
      if (!rst_n) begin
        pend_vld[i] = 1'b0;
        exp_data[i] = 8'h00;
        exp_ov[i]   = 1'b0;
      end else begin
        rdy = !pend_vld[i] || (edge_n - pend_edge[i] >= mc(i));
        exp_ov[i] = 1'b0;
        if (pend_vld[i] && (edge_n - pend_edge[i] == mc(i))) begin
          exp_ov[i]   = 1'b1;
          exp_data[i] = pend_data[i];
          pend_vld[i] = 1'b0;
        end
        if (in_valid[i] && rdy) begin
          pend_vld[i]  = 1'b1;
          pend_edge[i] = edge_n;
          pend_data[i] = in_data[i];
          src_rd[i]++;
        end
      end
    end
    #1;
    if (out_valid_w[1] === 1'b1) pulses1++;
    check_all();
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      src_wr[i]   = 0;
      src_rd[i]   = 0;
      in_valid[i] = 1'b0;
      in_data[i]  = 8'h00;
      pend_edge[i] = 0;
      pend_data[i] = 8'h00;
    end
    model_reset();

    // Reset state
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Accept 0xA5 on the 3-cycle stage, then reset asynchronously mid-HOLD
    push(0, 8'hA5);
    step();
    step();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    step();
    rst_n = 1'b1;
    src_rd[0] = src_wr[0];
    repeat (6) step();

    // Single word through every stage
    for (int i = 0; i < N; i++) push(i, 8'h3C);
    repeat (8) step();

    // Back-to-back streams; 16 words through the single-cycle stage
    pulses1 = 0;
    push(0, 8'h01); push(0, 8'h02); push(0, 8'h03);
    for (int k = 0; k < 16; k++) push(1, 8'(8'h10 + k));
    push(2, 8'h77); push(2, 8'h88);
    repeat (24) step();
    chk("m1_pulse_count", 32'(pulses1), 32'd16);

    // Stall on the 4-cycle stage: idle long enough to drop to IDLE, then restart
    push(2, 8'h5E);
    repeat (11) step();
    push(2, 8'hE5);
    repeat (8) step();

    // Random traffic with upstream gaps
    gap_en = 1'b1;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 2) == 0) push(i, 8'($urandom));
      step();
    end
    gap_en = 1'b0;
    repeat (20) step();

`ifdef MCP_PARITY_EN
    // Clean word, then a launch bit flipped during HOLD, then more clean words
    pd = 8'h5A; pv = 1'b1;
    step();
    pv = 1'b0;
    repeat (3) step();
    chk("par_err_clean", 32'(p_err), 32'd0);
    pd = 8'h5A; pv = 1'b1;
    step();
    pv = 1'b0;
    force u_par.launch_q_reg = 8'h5B;
    step();
    step();
    release u_par.launch_q_reg;
    chk("par_err_set", 32'(p_err), 32'd1);
    pd = 8'h33; pv = 1'b1;
    step();
    pv = 1'b0;
    repeat (4) step();
    chk("par_err_sticky", 32'(p_err), 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("par_err_reset", 32'(p_err), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
